axi_lite_arbiter: RTL and testbench
===================================

// Module: axi_lite_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between NUM_REQ local requesters, each with a simple command/done interface.
//  Round-robin arbitration; one outstanding transaction at a time (read or write).
//  Sits between control clients (DMA setup, CSR pokers, test sequencers) and the AXI-Lite interconnect.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   32  address width
//  DATA_W   32  data width; strobe width is DATA_W/8
// PORTS
//  aclk         in   1               clock; all logic on posedge
//  areset       in   1               reset, synchronous, active-high
//  req_valid    in   NUM_REQ         per-requester command request; held until req_gnt[i]
//  req_write    in   NUM_REQ         1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W  packed write data
//  req_wstrb    in   NUM_REQ*DATA_W/8  packed write strobes
//  req_gnt      out  NUM_REQ         one-hot 1-cycle pulse: command captured
//  req_done     out  NUM_REQ         one-hot 1-cycle pulse: transaction finished
//  rsp_rdata    out  DATA_W          read data, valid with req_done
//  rsp_resp     out  2               RRESP/BRESP, valid with req_done
//  busy         out  1               state != IDLE
//  m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready,
//  m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready,
//  m_axi_bresp/bvalid/bready   standard AXI4-Lite master channels
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=NUM_REQ-1 (req 0 wins first), all valid/ready/gnt/done/busy=0,
//    addr/data/strb/rsp outputs=0. Reset mid-transaction abandons it; no done is issued.
//  - States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
//  - IDLE: if any req_valid, pick first set bit searching from pointer+1 (mod NUM_REQ); pulse req_gnt[i],
//    capture write/addr/wdata/wstrb into registers, pointer<=i, go RADDR (read) or WREQ (write).
//    Requester may change or drop its fields after gnt.
//  - RADDR: arvalid=1, araddr=captured; on arvalid&&arready -> RDATA. ARADDR stable while arvalid.
//  - RDATA: rready=1; on rvalid -> capture rdata/rresp, go DONE.
//  - WREQ: awvalid and wvalid both raised on entry; each drops independently after its own handshake
//    (aw_done/w_done flags); same-cycle handshakes allowed. When both done -> WRESP.
//  - WRESP: bready=1; on bvalid -> capture bresp, rsp_rdata unchanged, go DONE.
//  - DONE: req_done[i]=1 for exactly one cycle with rsp_* valid -> IDLE. rsp_* hold until next DONE.
//  - Minimum latency gnt->done: read 3 cycles (zero-wait slave), write 3 cycles.
//  - First arbitration decision is one cycle after DONE; no back-to-back grant without an IDLE cycle.
//  - Outputs not in their active state drive 0 (addr/data included). rready/bready only in RDATA/WRESP.
//  - SLVERR/DECERR never retried; passed through unmodified on rsp_resp.
//  - Requests that drop before grant are ignored; no starvation: any held request granted within NUM_REQ turns.
// CONFIGURATION
//  AXI_ARB_PERF_EN defined: adds output perf_cnt [NUM_REQ*16] (16-bit per-requester count of completed
//   transactions, +1 in DONE, saturates at 16'hFFFF, cleared by reset) and perf_err [NUM_REQ*16]
//   (count of completions with rsp_resp!=0, same rules).
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 req0 read addr 0x4, arready=1, rvalid next cycle rdata=0xdeadbeef -> gnt[0], arvalid 1 cycle, done[0] rsp_rdata=0xdeadbeef resp=0.
//  2 req1 write 0x8/0x12345678 strb 0xF, awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 4, bresp=0 -> done[1].
//  3 req0..3 all held continuously, each completes -> grant order 0,1,2,3,0,1 ...
//  4 req0 & req2 raised same cycle after req2 was last served -> req0 first, then req2.
//  5 read with rresp=2'b10 -> done with rsp_resp=2'b10, no retry; perf_err[req] increments if AXI_ARB_PERF_EN.
//  6 assert areset in RDATA with rvalid pending -> next cycle all outputs 0, no req_done; new request served normally.

Source files
------------

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle used between the arbiter (master) and the interconnect (slave).
interface axi_lite_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ command/done requesters.
// One transaction in flight at a time. Define AXI_ARB_PERF_EN to add per-requester completion
// and error counters (perf_cnt / perf_err).
module axi_lite_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
`ifdef AXI_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0]       perf_cnt,
    output logic [NUM_REQ*16-1:0]       perf_err,
`endif
    axi_lite_arbiter_if.master          m_axi
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StDone} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;     // last granted requester, also owner of the transaction
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    int                  idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx  = (int'(ptr_q) + k) % int'(NUM_REQ);
            cand = IDX_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state, capture and AXI channel outputs; idle channels drive zero.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        rdata_d        = rdata_q;
        resp_d         = resp_q;
        req_gnt        = '0;
        req_done       = '0;
        m_axi.araddr   = '0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        m_axi.awaddr   = '0;
        m_axi.awvalid  = 1'b0;
        m_axi.wdata    = '0;
        m_axi.wstrb    = '0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                // No grant while in reset: the command would be lost.
                if (found && !areset) begin
                    req_gnt[pick] = 1'b1;
                    ptr_d         = pick;
                    wr_d          = req_write[pick];
                    addr_d        = req_addr[32'(pick) * ADDR_W +: ADDR_W];
                    wdata_d       = req_wdata[32'(pick) * DATA_W +: DATA_W];
                    wstrb_d       = req_wstrb[32'(pick) * STRB_W +: STRB_W];
                    state_d       = req_write[pick] ? StWreq : StRaddr;
                end
            end
            StRaddr: begin
                m_axi.arvalid = 1'b1;
                m_axi.araddr  = addr_q;
                if (m_axi.arready) state_d = StRdata;
            end
            StRdata: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    rdata_d = m_axi.rdata;
                    resp_d  = m_axi.rresp;
                    state_d = StDone;
                end
            end
            StWreq: begin
                m_axi.awvalid = !aw_done_q;
                m_axi.awaddr  = aw_done_q ? '0 : addr_q;
                m_axi.wvalid  = !w_done_q;
                m_axi.wdata   = w_done_q ? '0 : wdata_q;
                m_axi.wstrb   = w_done_q ? '0 : wstrb_q;
                aw_done_d     = aw_done_q | m_axi.awready;
                w_done_d      = w_done_q | m_axi.wready;
                if (aw_done_d && w_done_d) state_d = StWresp;
            end
            StWresp: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    state_d = StDone;
                end
            end
            StDone: begin
                req_done[ptr_q] = 1'b1;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    // State and capture registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= StIdle;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXI_ARB_PERF_EN
    logic [15:0] perf_cnt_q [NUM_REQ];
    logic [15:0] perf_cnt_d [NUM_REQ];
    logic [15:0] perf_err_q [NUM_REQ];
    logic [15:0] perf_err_d [NUM_REQ];

    // Saturating completion / error counts, bumped while the done pulse is out.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_err_d = perf_err_q;
        if (state_q == StDone) begin
            if (perf_cnt_q[ptr_q] != 16'hFFFF) perf_cnt_d[ptr_q] = perf_cnt_q[ptr_q] + 16'd1;
            if (resp_q != 2'b00 && perf_err_q[ptr_q] != 16'hFFFF) begin
                perf_err_d[ptr_q] = perf_err_q[ptr_q] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                perf_cnt_q[i] <= '0;
                perf_err_q[i] <= '0;
            end
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_err_q <= perf_err_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_perf_pack
        assign perf_cnt[g*16 +: 16] = perf_cnt_q[g];
        assign perf_err[g*16 +: 16] = perf_err_q[g];
    end
`endif

    logic unused_wr;
    assign unused_wr = wr_q;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: transaction-level model checked every cycle plus directed cases.
module tb_axi_lite_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_wstrb = '0;
    logic [N-1:0]    req_gnt;
    logic [N-1:0]    req_done;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
`ifdef AXI_ARB_PERF_EN
    logic [N*16-1:0] perf_cnt;
    logic [N*16-1:0] perf_err;
`endif

    axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_axi ();

    axi_lite_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_gnt   (req_gnt),
        .req_done  (req_done),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy),
`ifdef AXI_ARB_PERF_EN
        .perf_cnt  (perf_cnt),
        .perf_err  (perf_err),
`endif
        .m_axi     (m_axi.master)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Slave behaviour knobs: cycles of valid/ready before the slave answers.
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int          rq_left [N];
    logic [N-1:0] gnt_seen = '0;

    // Slave responder and requester hold/drop behaviour, driven 1 time unit after the edge.
    always @(posedge aclk) begin
        #1;
        if (m_axi.arvalid === 1'b1) begin m_axi.arready = (ar_cnt == ar_dly); ar_cnt++; end
        else begin m_axi.arready = 1'b0; ar_cnt = 0; end
        if (m_axi.rready === 1'b1) begin
            m_axi.rvalid = (r_cnt == r_dly); r_cnt++;
        end else begin m_axi.rvalid = 1'b0; r_cnt = 0; end
        m_axi.rdata = m_axi.rvalid ? s_rdata : '0;
        m_axi.rresp = m_axi.rvalid ? s_rresp : '0;
        if (m_axi.awvalid === 1'b1) begin m_axi.awready = (aw_cnt == aw_dly); aw_cnt++; end
        else begin m_axi.awready = 1'b0; aw_cnt = 0; end
        if (m_axi.wvalid === 1'b1) begin m_axi.wready = (w_cnt == w_dly); w_cnt++; end
        else begin m_axi.wready = 1'b0; w_cnt = 0; end
        if (m_axi.bready === 1'b1) begin m_axi.bvalid = (b_cnt == b_dly); b_cnt++; end
        else begin m_axi.bvalid = 1'b0; b_cnt = 0; end
        m_axi.bresp = m_axi.bvalid ? s_bresp : '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_seen[i]) begin
                if (rq_left[i] > 1) begin
                    rq_left[i]--;
                    req_addr[i*AW +: AW] = req_addr[i*AW +: AW] + 32'd4;
                end else begin
                    rq_left[i]   = 0;
                    req_valid[i] = 1'b0;
                end
            end
        end
        gnt_seen = '0;
    end

    // Transaction-level model: which channel is outstanding, who owns it, last response.
    bit          m_ar, m_r, m_aw, m_w, m_b, m_done;
    int          m_idx, m_last;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_resp;
    int          m_pcnt [N];
    int          m_perr [N];

    function automatic bit model_idle();
        return !(m_ar || m_r || m_aw || m_w || m_b || m_done);
    endfunction

    // Observations used by the directed checks.
    int          cyc = 0;
    int          gnt_log[$];
    int          gnt_cyc, done_cyc, done_idx, done_cnt, ar_hi, aw_hi, w_hi;
    logic [31:0] rec_rdata;
    logic [1:0]  rec_resp;

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge aclk) begin : cmp
        bit           idle, found;
        int           pick, j;
        logic [N-1:0] e_gnt, e_done;
        cyc++;
        if (areset) begin
            m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; m_done = 0;
            m_idx = 0; m_last = int'(N) - 1; m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_rdata = '0; m_resp = '0;
            for (int i = 0; i < int'(N); i++) begin m_pcnt[i] = 0; m_perr[i] = 0; end
            gnt_seen = '0;
        end else begin
            idle = model_idle();
            found = 0; pick = 0;
            if (idle) begin
                for (int k = 1; k <= int'(N); k++) begin
                    j = (m_last + k) % int'(N);
                    if (!found && req_valid[j]) begin found = 1; pick = j; end
                end
            end
            e_gnt  = found ? (N'(1) << pick) : '0;
            e_done = m_done ? (N'(1) << m_idx) : '0;
            chk("gnt", req_gnt, e_gnt);
            chk("done", req_done, e_done);
            chk("busy", busy, !idle);
            chk("arvalid", m_axi.arvalid, m_ar);
            chk("araddr", m_axi.araddr, m_ar ? m_addr : 32'h0);
            chk("rready", m_axi.rready, m_r);
            chk("awvalid", m_axi.awvalid, m_aw);
            chk("awaddr", m_axi.awaddr, m_aw ? m_addr : 32'h0);
            chk("wvalid", m_axi.wvalid, m_w);
            chk("wdata", m_axi.wdata, m_w ? m_wdata : 32'h0);
            chk("wstrb", m_axi.wstrb, m_w ? m_wstrb : 4'h0);
            chk("bready", m_axi.bready, m_b);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_resp", rsp_resp, m_resp);
`ifdef AXI_ARB_PERF_EN
            for (int i = 0; i < int'(N); i++) begin
                chk("perf_cnt", perf_cnt[i*16 +: 16], 16'(m_pcnt[i]));
                chk("perf_err", perf_err[i*16 +: 16], 16'(m_perr[i]));
            end
`endif
            // Observations
            gnt_seen = req_gnt;
            if (req_gnt != '0) begin gnt_log.push_back(onehot_idx(req_gnt)); gnt_cyc = cyc; end
            if (req_done != '0) begin
                done_idx = onehot_idx(req_done); done_cyc = cyc; done_cnt++;
                rec_rdata = rsp_rdata; rec_resp = rsp_resp;
            end
            if (m_axi.arvalid) ar_hi++;
            if (m_axi.awvalid) aw_hi++;
            if (m_axi.wvalid) w_hi++;
            // Model step
            if (m_done) begin
                if (m_pcnt[m_idx] < 16'hFFFF) m_pcnt[m_idx]++;
                if (m_resp != 2'b00 && m_perr[m_idx] < 16'hFFFF) m_perr[m_idx]++;
                m_done = 0;
            end else if (idle) begin
                if (found) begin
                    m_idx = pick; m_last = pick;
                    m_addr = req_addr[pick*AW +: AW];
                    m_wdata = req_wdata[pick*DW +: DW];
                    m_wstrb = req_wstrb[pick*SW +: SW];
                    if (req_write[pick]) begin m_aw = 1; m_w = 1; end else m_ar = 1;
                end
            end else if (m_ar) begin
                if (m_axi.arready) begin m_ar = 0; m_r = 1; end
            end else if (m_r) begin
                if (m_axi.rvalid) begin
                    m_r = 0; m_rdata = m_axi.rdata; m_resp = m_axi.rresp; m_done = 1;
                end
            end else if (m_aw || m_w) begin
                if (m_aw && m_axi.awready) m_aw = 0;
                if (m_w && m_axi.wready) m_w = 0;
                if (!m_aw && !m_w) m_b = 1;
            end else if (m_b) begin
                if (m_axi.bvalid) begin m_b = 0; m_resp = m_axi.bresp; m_done = 1; end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_obs();
        gnt_log.delete();
        done_cnt = 0; ar_hi = 0; aw_hi = 0; w_hi = 0; done_idx = -1;
    endtask

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int cnt);
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
        rq_left[i] = cnt;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_quiet(input string nm);
        int n;
        n = 0;
        step();
        while ((req_valid != '0 || !model_idle()) && n < 400) begin step(); n++; end
        chk({nm, "_quiet"}, 64'(n < 400), 64'd1);
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        step();
        areset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int exp3 [8];
        int n;
        exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < int'(N); i++) rq_left[i] = 0;
        repeat (3) @(posedge aclk);
        #2;
        areset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", m_axi.arvalid, 0);
        chk("rst_done", req_done, 0);
        chk("rst_rdata", rsp_rdata, 0);

        // 1: single read, zero-wait slave
        s_rdata = 32'hdeadbeef; s_rresp = 2'b00;
        clear_obs();
        issue(0, 1'b0, 32'h4, 32'h0, 4'h0, 1);
        wait_quiet("t1");
        chk("t1_ngnt", gnt_log.size(), 1);
        chk("t1_done_idx", done_idx, 0);
        chk("t1_latency", done_cyc - gnt_cyc, 3);
        chk("t1_ar_cycles", ar_hi, 1);
        chk("t1_rdata", rec_rdata, 32'hdeadbeef);
        chk("t1_resp", rec_resp, 2'b00);

        // 2: write with awready delayed 3 cycles
        aw_dly = 3; s_bresp = 2'b00;
        clear_obs();
        issue(1, 1'b1, 32'h8, 32'h12345678, 4'hF, 1);
        wait_quiet("t2");
        aw_dly = 0;
        chk("t2_aw_cycles", aw_hi, 4);
        chk("t2_w_cycles", w_hi, 1);
        chk("t2_done_idx", done_idx, 1);
        chk("t2_latency", done_cyc - gnt_cyc, 6);
        chk("t2_rdata_hold", rec_rdata, 32'hdeadbeef);

        // 3: all four held from a fresh reset -> strict rotation
        pulse_reset();
        s_rdata = 32'h00001111;
        clear_obs();
        for (int i = 0; i < int'(N); i++) issue(i, 1'b0, 32'h100 * i, 32'h0, 4'h0, 2);
        wait_quiet("t3");
        chk("t3_ngnt", gnt_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t3_order", gnt_log[i], exp3[i]);

        // 4: req2 served last, then req0 and req2 together
        clear_obs();
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0, 1);
        wait_quiet("t4a");
        clear_obs();
        issue(0, 1'b0, 32'h24, 32'h0, 4'h0, 1);
        issue(2, 1'b0, 32'h28, 32'h0, 4'h0, 1);
        wait_quiet("t4b");
        chk("t4_ngnt", gnt_log.size(), 2);
        chk("t4_first", gnt_log[0], 0);
        chk("t4_second", gnt_log[1], 2);

        // 5: SLVERR read passed through, no retry
        s_rresp = 2'b10; s_rdata = 32'h0bad0bad;
        clear_obs();
        issue(3, 1'b0, 32'h30, 32'h0, 4'h0, 1);
        wait_quiet("t5");
        s_rresp = 2'b00;
        chk("t5_ngnt", gnt_log.size(), 1);
        chk("t5_done_idx", done_idx, 3);
        chk("t5_resp", rec_resp, 2'b10);
        repeat (3) step();
        chk("t5_no_retry", gnt_log.size(), 1);
`ifdef AXI_ARB_PERF_EN
        chk("t5_perf_err3", perf_err[3*16 +: 16], 16'd1);
        chk("t5_perf_cnt3", perf_cnt[3*16 +: 16], 16'd3);
`endif

        // 6: reset while waiting for read data
        r_dly = 50;
        clear_obs();
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
        n = 0;
        while (!m_r && n < 20) begin step(); n++; end
        chk("t6_reach_rdata", 64'(m_r), 64'd1);
        pulse_reset();
        chk("t6_rready", m_axi.rready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_arvalid", m_axi.arvalid, 0);
        chk("t6_rsp", rsp_rdata, 0);
        repeat (4) step();
        chk("t6_no_done", done_cnt, 0);
        r_dly = 0; s_rdata = 32'hcafef00d;
        clear_obs();
        issue(1, 1'b0, 32'h44, 32'h0, 4'h0, 1);
        wait_quiet("t6b");
        chk("t6_done_idx", done_idx, 1);
        chk("t6_rdata", rec_rdata, 32'hcafef00d);
        chk("t6_done_cnt", done_cnt, 1);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
